// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV64 core constants and fetch state encoding
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_STEP   = 4;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        FLUSH = 3'd3,
        HOLD  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch stage with redirect flush
module instr_fetch_unit #(
    parameter int                XLEN     = 64,
    parameter int                ILEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready
);
    import riscv_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] redirect_target;

    // Redirect targets are word aligned; the low two bits are simply masked off.
    assign redirect_target = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= ILEN'(NOP_INSTR);
            if_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            if_pc_q <= if_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if_pc_d = if_pc_q;
        unique case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = imem_req_ready ? FLUSH : REQ;
                end else if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = imem_resp_valid ? REQ : FLUSH;
                end else if (imem_resp_valid) begin
                    instr_d = imem_resp_data;
                    if_pc_d = pc_q;
                    state_d = HOLD;
                end
            end
            FLUSH: begin
                // The stale word retires the outstanding request, so leave even if redirected again.
                if (redirect_valid) pc_d = redirect_target;
                if (imem_resp_valid) state_d = REQ;
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = REQ;
                end else if (if_ready) begin
                    pc_d    = pc_q + XLEN'(PC_STEP);
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign if_valid       = (state_q == HOLD);
    assign if_instr       = instr_q;
    assign if_pc          = if_pc_q;

endmodule
